// File: rtl/float_pipe_pkg.sv
// float_pipe_pkg: shared state encodings and stage bundle widths for the float datapath
package float_pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_BUSY = 2'd1, ST_FULL = 2'd2} state_t;
  localparam int FA_A2C_W = 87;
  // rm 2 + inf_nan 1 + sign 1 + inf_nan_frac 23 + exp 8 + sum 28
  localparam int FA_C2N_W = 63;
endpackage

// File: rtl/float_pipe_stage_reg.sv
// float_pipe_stage_reg: elastic valid/ready pipeline register with optional two-entry skid
module float_pipe_stage_reg
  import float_pipe_pkg::*;
#(
  parameter int DATA_W = FA_A2C_W,
  parameter bit SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  state_t state, nxt;
  logic [DATA_W-1:0] main, skid;
  logic acc;
  assign acc = in_valid & in_ready;
  assign out_data = main;
  always_ff @(posedge clk)
    if (rst) state <= ST_EMPTY;
    else state <= nxt;
  always_comb
    nxt = flush ? ST_EMPTY :
          state == ST_EMPTY ? (acc ? ST_BUSY : ST_EMPTY) :
          state == ST_BUSY ? (acc && !out_ready ? ST_FULL :
                              !acc && out_ready ? ST_EMPTY : ST_BUSY) :
          (out_ready ? ST_BUSY : ST_FULL);
  always_comb begin
    out_valid = state != ST_EMPTY;
    occupancy = state;
  end
  // flush discards entries by state only; the data registers keep their contents
  always_ff @(posedge clk)
    if (rst) main <= '0;
    else if (!flush && acc && (state == ST_EMPTY || out_ready)) main <= in_data;
    else if (!flush && state == ST_FULL && out_ready) main <= skid;
  if (SKID) begin : g_skid
    logic rdy;
    always_ff @(posedge clk)
      if (rst) begin
        skid <= '0;
        rdy <= 1'b0;
      end else begin
        rdy <= nxt != ST_FULL;
        if (!flush && state == ST_BUSY && acc && !out_ready) skid <= in_data;
      end
    assign in_ready = rdy;
  end else begin : g_noskid
    assign skid = '0;
    assign in_ready = !out_valid || out_ready;
  end
endmodule

// File: tb/tb_float_pipe_stage_reg.sv
// tb_float_pipe_stage_reg: four DUT variants (8/87 bit, SKID 0/1) checked against queue models
module tb_float_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [86:0] in_data;
  logic ir[4], ov[4];
  logic [1:0] occ[4];
  logic [86:0] od[4];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [86:0] a, input logic [86:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W = (g % 2 == 1) ? 87 : 8;
    localparam bit S = g >= 2;
    logic [W-1:0] d;
    logic [W-1:0] q[$];
    bit mr;
    float_pipe_stage_reg #(.DATA_W(W), .SKID(S)) u (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[g]), .in_data(in_data[W-1:0]),
      .out_valid(ov[g]), .out_ready(out_ready), .out_data(d),
      .occupancy(occ[g])
    );
    assign od[g] = 87'(d);
    // model: a FIFO of held bundles, capacity 2 with skid, 1 without
    initial begin
      bit rn, acc, del;
      mr = 1'b0;
      forever begin
        @(posedge clk);
        rn = S ? mr : (q.size() == 0 || out_ready);
        acc = in_valid && rn;
        del = out_ready && q.size() > 0;
        if (rst) begin
          q.delete();
          mr = 1'b0;
        end else begin
          if (flush) q.delete();
          else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back(in_data[W-1:0]);
          end
          mr = q.size() < 2;
        end
      end
    end
    initial begin
      bit er;
      @(posedge clk);
      forever begin
        @(negedge clk);
        er = S ? mr : (q.size() == 0 || out_ready);
        chk($sformatf("g%0d occupancy", g), 87'(occ[g]), 87'(q.size()));
        chk($sformatf("g%0d out_valid", g), 87'(ov[g]), 87'(q.size() > 0));
        chk($sformatf("g%0d in_ready", g), 87'(ir[g]), 87'(er));
        if (q.size() > 0) chk($sformatf("g%0d out_data", g), od[g], 87'(q[0]));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 87'h1;
    repeat (3) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        chk("rst out_valid", 87'(ov[k]), 87'd0);
        chk("rst out_data", od[k], 87'd0);
        chk("rst occupancy", 87'(occ[k]), 87'd0);
        if (k >= 2) chk("rst in_ready", 87'(ir[k]), 87'd0);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) chk("post-rst in_ready", 87'(ir[k]), 87'd1);
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1; in_data = 87'(i);
      tick();
      chk("stream data s1", od[3], 87'(i));
      chk("stream occ s1", 87'(occ[3]), 87'd1);
      chk("stream data s0", od[1], 87'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream drained", 87'(ov[3]), 87'd0);
    in_valid = 1'b1; in_data = 87'd5;
    tick();
    chk("stall A", od[3], 87'd5);
    in_data = 87'd6; out_ready = 1'b0;
    #1;
    chk("s0 comb in_ready", 87'(ir[1]), 87'd0);
    tick();
    chk("stall occ", 87'(occ[3]), 87'd2);
    chk("stall in_ready", 87'(ir[3]), 87'd0);
    chk("stall hold A", od[3], 87'd5);
    in_valid = 1'b0;
    tick();
    chk("stall hold A2", od[3], 87'd5);
    out_ready = 1'b1;
    tick();
    chk("drain B", od[3], 87'd6);
    chk("drain occ", 87'(occ[3]), 87'd1);
    tick();
    chk("drained", 87'(ov[3]), 87'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 87'hA;
    tick();
    in_data = 87'hB;
    tick();
    chk("flush pre occ", 87'(occ[3]), 87'd2);
    flush = 1'b1; in_data = 87'hC;
    tick();
    chk("flush out_valid", 87'(ov[3]), 87'd0);
    chk("flush occ", 87'(occ[3]), 87'd0);
    chk("flush in_ready", 87'(ir[3]), 87'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush C dropped", 87'(ov[3]), 87'd0);
    repeat (10000) begin
      rst = $urandom_range(0, 999) == 0;
      flush = $urandom_range(0, 49) == 0;
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      in_data = 87'({$urandom(), $urandom(), $urandom()});
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
